imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving the instruction-memory size in 32-bit words.
REQ-002 SHALL have parameter AW, default 6, giving the address width; DEPTH SHALL equal 2**AW.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  one-cycle pulse that begins a program load.
REQ-006 In_Data  input  8  program byte stream, big-endian within each word.
REQ-007 In_Valid  input  1  In_Data is valid this cycle.
REQ-008 In_Ready  output  1  loader accepts In_Data this cycle.
REQ-009 Mem_We  output  1  instruction-memory write strobe.
REQ-010 Mem_Addr  output  AW  instruction-memory word address.
REQ-011 Mem_WData  output  32  instruction-memory write data.
REQ-012 Cpu_Rst  output  1  active-high reset to the CPU core; held during load.
REQ-013 Busy  output  1  a load is in progress.
REQ-014 Done  output  1  a load has completed.
REQ-015 Word_Count  output  AW+1  number of program words written, excluding marker and fill words.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, WRITE, FILL and DONE.
REQ-017 In IDLE or DONE, Start=1 SHALL clear the address, byte index and Word_Count, and SHALL enter LOAD on the next edge.
REQ-018 Start SHALL be ignored in LOAD, WRITE and FILL.
REQ-019 In_Ready SHALL be 1 only in LOAD; a byte is accepted when In_Valid and In_Ready are both 1.
REQ-020 Accepted bytes SHALL be assembled MSB first: byte 0 to [31:24], byte 3 to [7:0]; gaps in In_Valid SHALL NOT lose or reorder bytes.
REQ-021 Acceptance of the fourth byte SHALL move the FSM to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with Mem_We=1, Mem_Addr=current address and Mem_WData=the assembled word.
REQ-023 After WRITE, if the word equals 32'hFFFFFFFF (the end marker), the FSM SHALL go to FILL when the fill feature is enabled, otherwise to DONE.
REQ-024 After WRITE, if the word is not the marker, Word_Count SHALL increment.
REQ-025 After WRITE, if the word is not the marker and the address equals DEPTH-1, the FSM SHALL go to DONE.
REQ-026 After WRITE, if the word is not the marker and the address is below DEPTH-1, the address SHALL increment and the FSM SHALL return to LOAD.
REQ-027 The address SHALL never wrap; no write SHALL occur beyond DEPTH-1.
REQ-028 Busy SHALL be 1 in LOAD, WRITE and FILL; Cpu_Rst SHALL be 1 in every state except DONE.
REQ-029 Done SHALL be 1 only in DONE and SHALL hold until the next accepted Start.
REQ-030 Mem_We SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-031 Asserting Rst SHALL immediately force IDLE, Cpu_Rst=1, and In_Ready, Mem_We, Busy and Done to 0.
REQ-032 Asserting Rst SHALL immediately force Mem_Addr, Mem_WData and Word_Count to 0.
REQ-033 Rst asserted mid-word SHALL discard the partial word and perform no write.

Configuration
REQ-034 With IMEM_LOADER_FILL_EN defined, FILL SHALL write 32'hFFFFFFFF once per cycle to every address after the marker address up to DEPTH-1, then enter DONE.
REQ-035 If the marker lands at DEPTH-1, FILL SHALL write nothing.
REQ-036 Without IMEM_LOADER_FILL_EN, FILL SHALL be unreachable and locations after the marker SHALL be left untouched.

Structure
REQ-037 A shared package SHALL hold the FSM state typedef, the marker constant 32'hFFFFFFFF and the default DEPTH/AW constants.
REQ-038 The block SHALL have one sub-module, imem_word_packer, which packs bytes to words (byte index and shift register) and flags a full word.

Verification
REQ-039 Start, bytes 20 02 00 05 then FF FF FF FF -> addr 0 gets 20020005, addr 1 gets FFFFFFFF; Word_Count=1; Done=1 and Cpu_Rst=0.
REQ-040 Same bytes with In_Valid toggling 1/0 -> identical writes; In_Ready=0 during each WRITE cycle.
REQ-041 64 non-marker words -> last write at addr 63; DONE; Word_Count=64; further bytes not accepted (In_Ready=0).
REQ-042 Marker as fourth word with IMEM_LOADER_FILL_EN -> 61 FFFFFFFF writes at addrs 3..63.
REQ-043 Marker as fourth word without IMEM_LOADER_FILL_EN -> single write at addr 3, then DONE.
REQ-044 Rst after 2 bytes, then reload -> no write before the reload; first write lands at addr 0 with the new data.
REQ-045 Start pulsed mid-LOAD -> ignored; address and byte index unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature: IMEM_LOADER_FILL_EN (pads memory after the end marker).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] END_MARKER    = 32'hFFFF_FFFF;
  localparam int          DEFAULT_DEPTH = 64;
  localparam int          DEFAULT_AW    = 6;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles a big-endian byte stream into 32-bit words; flags the cycle in
// which the fourth byte of a word is accepted.
module imem_word_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // The word is completed combinationally so the top can latch it on the
  // same edge that accepts the last byte.
  assign o_word = {r_shift, i_byte};
  assign o_full = i_accept && (r_idx == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_clr) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_accept) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wide program into instruction memory while holding the CPU in
// reset. Optional IMEM_LOADER_FILL_EN pads the locations after the end marker.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_cpu_rst,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW:0]   o_word_count
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_t        r_state;
  logic          r_in_ready;
  logic          r_mem_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_cpu_rst;
  logic          r_busy;
  logic          r_done;
  logic [AW:0]   r_word_count;

  logic          w_accept;
  logic          w_clr;
  logic          w_full;
  logic [31:0]   w_word;
  logic          w_last_addr;

  assign w_accept    = i_in_valid && r_in_ready;
  assign w_clr       = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_addr = (r_addr == ADDR_LAST);

  imem_word_packer u_packer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .i_accept (w_accept),
    .i_byte   (i_in_data),
    .o_word   (w_word),
    .o_full   (w_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state      <= ST_LOAD;
            r_addr       <= '0;
            r_word_count <= '0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_cpu_rst    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_full) begin
            r_state    <= ST_WRITE;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b1;
            r_wdata    <= w_word;
          end
        end
        ST_WRITE: begin
          r_mem_we <= 1'b0;
          if (r_wdata == END_MARKER) begin
`ifdef IMEM_LOADER_FILL_EN
            if (w_last_addr) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              // r_wdata already holds the marker, which doubles as fill data
              r_state  <= ST_FILL;
              r_addr   <= r_addr + ADDR_ONE;
              r_mem_we <= 1'b1;
            end
`else
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
`endif
          end else begin
            r_word_count <= r_word_count + CNT_ONE;
            if (w_last_addr) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state    <= ST_LOAD;
              r_addr     <= r_addr + ADDR_ONE;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_last_addr) begin
            r_state   <= ST_DONE;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_addr <= r_addr + ADDR_ONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_mem_we   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: checks captured memory writes and status
// outputs against hand-computed values; follows IMEM_LOADER_FILL_EN if defined.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [7:0]    i_in_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_cpu_rst;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_word_count;

  int n_vec = 0;
  int n_err = 0;

  // write log filled by the monitor
  int          wr_cnt = 0;
  int          ready_in_write = 0;
  logic [31:0] log_addr [0:2047];
  logic [31:0] log_data [0:2047];

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_mem_we) begin
      if (wr_cnt < 2048) begin
        log_addr[wr_cnt] = 32'(o_mem_addr);
        log_data[wr_cnt] = o_mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
      if (o_in_ready) ready_in_write = ready_in_write + 1;
      $display("write addr=%0d data=%08h", o_mem_addr, o_mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    i_in_valid = 1'b1;
    i_in_data  = b;
    while (!o_in_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_in_ready) check("ready_timeout", 32'(o_in_ready), 32'd1);
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("done_reached", 32'(o_done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(o_in_ready), 32'd0);
    check("rst_we",    32'(o_mem_we),   32'd0);
    check("rst_busy",  32'(o_busy),     32'd0);
    check("rst_done",  32'(o_done),     32'd0);
    check("rst_cpu",   32'(o_cpu_rst),  32'd1);
    check("rst_addr",  32'(o_mem_addr), 32'd0);
    check("rst_wdata", o_mem_wdata,     32'd0);
    check("rst_count", 32'(o_word_count), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  function automatic logic [31:0] seq_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA0, b, 8'h5A, ~b};
  endfunction

  initial begin
    int base;
    int exp_fill_writes;
    i_rst_n    = 1'b1;
    i_start    = 1'b0;
    i_in_data  = 8'h00;
    i_in_valid = 1'b0;
    #2;
    do_reset();

    // basic load: one word then marker
    base = wr_cnt;
    pulse_start();
    check("load_busy", 32'(o_busy), 32'd1);
    check("load_cpu",  32'(o_cpu_rst), 32'd1);
    send_word(32'h2002_0005, 0);
    send_word(32'hFFFF_FFFF, 0);
    wait_done(200);
`ifdef IMEM_LOADER_FILL_EN
    exp_fill_writes = 62;
`else
    exp_fill_writes = 0;
`endif
    check("b_nwrites", 32'(wr_cnt - base), 32'(2 + exp_fill_writes));
    check("b_addr0", log_addr[base],     32'd0);
    check("b_data0", log_data[base],     32'h2002_0005);
    check("b_addr1", log_addr[base + 1], 32'd1);
    check("b_data1", log_data[base + 1], 32'hFFFF_FFFF);
    check("b_count", 32'(o_word_count), 32'd1);
    check("b_done",  32'(o_done), 32'd1);
    check("b_cpu",   32'(o_cpu_rst), 32'd0);
    check("b_busy",  32'(o_busy), 32'd0);

    // same program with In_Valid toggling
    base = wr_cnt;
    ready_in_write = 0;
    pulse_start();
    send_word(32'h2002_0005, 1);
    send_word(32'hFFFF_FFFF, 1);
    wait_done(200);
    check("t_nwrites", 32'(wr_cnt - base), 32'(2 + exp_fill_writes));
    check("t_data0", log_data[base],     32'h2002_0005);
    check("t_addr1", log_addr[base + 1], 32'd1);
    check("t_data1", log_data[base + 1], 32'hFFFF_FFFF);
    check("t_ready_in_write", 32'(ready_in_write), 32'd0);

    // full memory of non-marker words
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 64; i++) send_word(seq_word(i), 0);
    wait_done(50);
    check("f_nwrites",  32'(wr_cnt - base), 32'd64);
    check("f_addr5",    log_addr[base + 5], 32'd5);
    check("f_data5",    log_data[base + 5], 32'hA005_5AFA);
    check("f_last_addr", log_addr[base + 63], 32'd63);
    check("f_last_data", log_data[base + 63], 32'hA03F_5AC0);
    check("f_count",    32'(o_word_count), 32'd64);
    i_in_valid = 1'b1;
    i_in_data  = 8'h12;
    repeat (8) @(posedge i_clk);
    #1;
    check("f_ready_after", 32'(o_in_ready), 32'd0);
    check("f_no_extra",    32'(wr_cnt - base), 32'd64);
    i_in_valid = 1'b0;

    // marker as fourth word
    base = wr_cnt;
    pulse_start();
    check("m_done_cleared", 32'(o_done), 32'd0);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0003, 0);
    send_word(32'hFFFF_FFFF, 0);
    wait_done(200);
    repeat (4) @(posedge i_clk);
    #1;
`ifdef IMEM_LOADER_FILL_EN
    check("m_nwrites",   32'(wr_cnt - base), 32'd64);
    check("m_fill_addr", log_addr[base + 63], 32'd63);
    check("m_fill_data", log_data[base + 63], 32'hFFFF_FFFF);
    check("m_fill_mid",  log_addr[base + 10], 32'd10);
`else
    check("m_nwrites",   32'(wr_cnt - base), 32'd4);
`endif
    check("m_marker_addr", log_addr[base + 3], 32'd3);
    check("m_marker_data", log_data[base + 3], 32'hFFFF_FFFF);
    check("m_count",       32'(o_word_count), 32'd3);

    // reset mid-word, then reload
    base = wr_cnt;
    pulse_start();
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    do_reset();
    check("r_no_write", 32'(wr_cnt - base), 32'd0);
    pulse_start();
    send_word(32'hABCD_EF01, 0);
    @(posedge i_clk); #1;
    check("r_first_addr", log_addr[base], 32'd0);
    check("r_first_data", log_data[base], 32'hABCD_EF01);
    send_word(32'hFFFF_FFFF, 0);
    wait_done(200);

    // Start pulsed in the middle of a word
    base = wr_cnt;
    pulse_start();
    send_word(32'h0102_0304, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    check("s_addr",  32'(o_mem_addr), 32'd1);
    check("s_busy",  32'(o_busy), 32'd1);
    check("s_ready", 32'(o_in_ready), 32'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    @(posedge i_clk); #1;
    check("s_addr1", log_addr[base + 1], 32'd1);
    check("s_data1", log_data[base + 1], 32'h1122_3344);
    send_word(32'hFFFF_FFFF, 0);
    wait_done(200);
    check("s_count", 32'(o_word_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
